arr_peak_search: RTL and testbench

- Downstream consumer of the non-coherent array accumulator output stream (R_out/valid of the NKG stage).
- Scans each frame of N_args accumulated correlation values (one per code-phase/frequency argument).
- Reports the maximum value and its index, the second-largest value, the frame sum (noise-floor estimate) and a threshold decision.
- Results are held stable for the acquisition controller / register bank until the next frame completes.

---
 rtl/arr_peak_search.sv | 143 ++++++++++++++
 tb/tb_arr_peak_search.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arr_peak_search.sv
// Frame-based peak search over the non-coherent accumulator stream: tracks max/argmax,
// second-largest and frame sum, then publishes them with a one-cycle done pulse per frame.
module arr_peak_search #(
    parameter int IN_WIDTH  = 30,
    parameter int N_args    = 64,
    parameter int IDX_WIDTH = $clog2(N_args),
    parameter int SUM_WIDTH = IN_WIDTH + $clog2(N_args)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic signed [IN_WIDTH-1:0]  R_in,
    input  logic                        we,
    input  logic                        clr,
    input  logic signed [IN_WIDTH-1:0]  threshold,
    output logic signed [IN_WIDTH-1:0]  peak_val,
    output logic [IDX_WIDTH-1:0]        peak_idx,
    output logic signed [IN_WIDTH-1:0]  second_val,
    output logic signed [SUM_WIDTH-1:0] sum,
    output logic                        detect,
    output logic                        done,
    output logic                        dbg_state
);

    // Handshake: we is a qualifying strobe with no backpressure; every cycle with we=1
    // and clr=0 consumes R_in as the next argument of the current frame.
    typedef enum logic {SCAN_FIRST = 1'b0, SCAN = 1'b1} state_e;

    localparam int EXT = SUM_WIDTH - IN_WIDTH;
    localparam logic signed [IN_WIDTH-1:0] MOST_NEG = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_args - 1);

    state_e                      state_q, state_d;
    logic [IDX_WIDTH-1:0]        idx_q, idx_d;
    logic signed [IN_WIDTH-1:0]  wmax_q, wmax_d;
    logic [IDX_WIDTH-1:0]        wmax_idx_q, wmax_idx_d;
    logic signed [IN_WIDTH-1:0]  wsec_q, wsec_d;
    logic signed [SUM_WIDTH-1:0] wsum_q, wsum_d;
    logic signed [IN_WIDTH-1:0]  peak_val_q, peak_val_d;
    logic [IDX_WIDTH-1:0]        peak_idx_q, peak_idx_d;
    logic signed [IN_WIDTH-1:0]  second_val_q, second_val_d;
    logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                        detect_q, detect_d;
    logic                        done_q, done_d;
    logic signed [SUM_WIDTH-1:0] r_ext;
    logic                        frame_end;

    assign r_ext = {{EXT{R_in[IN_WIDTH-1]}}, R_in};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wmax_d       = wmax_q;
        wmax_idx_d   = wmax_idx_q;
        wsec_d       = wsec_q;
        wsum_d       = wsum_q;
        peak_val_d   = peak_val_q;
        peak_idx_d   = peak_idx_q;
        second_val_d = second_val_q;
        sum_d        = sum_q;
        detect_d     = detect_q;
        done_d       = 1'b0;
        frame_end    = 1'b0;

        if (clr) begin
            idx_d   = '0;
            state_d = SCAN_FIRST;
        end else if (we) begin
            if (state_q == SCAN_FIRST) begin
                wmax_d     = R_in;
                wmax_idx_d = '0;
                wsec_d     = MOST_NEG;
                wsum_d     = r_ext;
            end else begin
                // Strict compare keeps the earliest index; an equal value lands in second.
                if (R_in > wmax_q) begin
                    wsec_d     = wmax_q;
                    wmax_d     = R_in;
                    wmax_idx_d = idx_q;
                end else if (R_in > wsec_q) begin
                    wsec_d = R_in;
                end
                wsum_d = wsum_q + r_ext;
            end

            frame_end = (idx_q == LAST_IDX);
            if (frame_end) begin
                idx_d   = '0;
                state_d = SCAN_FIRST;
            end else begin
                idx_d   = idx_q + IDX_WIDTH'(1);
                state_d = SCAN;
            end
        end

        if (frame_end) begin
            peak_val_d   = wmax_d;
            peak_idx_d   = wmax_idx_d;
            second_val_d = wsec_d;
            sum_d        = wsum_d;
            detect_d     = (wmax_d > threshold);
            done_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= SCAN_FIRST;
            idx_q        <= '0;
            wmax_q       <= '0;
            wmax_idx_q   <= '0;
            wsec_q       <= '0;
            wsum_q       <= '0;
            peak_val_q   <= '0;
            peak_idx_q   <= '0;
            second_val_q <= '0;
            sum_q        <= '0;
            detect_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wmax_q       <= wmax_d;
            wmax_idx_q   <= wmax_idx_d;
            wsec_q       <= wsec_d;
            wsum_q       <= wsum_d;
            peak_val_q   <= peak_val_d;
            peak_idx_q   <= peak_idx_d;
            second_val_q <= second_val_d;
            sum_q        <= sum_d;
            detect_q     <= detect_d;
            done_q       <= done_d;
        end
    end

    assign peak_val   = peak_val_q;
    assign peak_idx   = peak_idx_q;
    assign second_val = second_val_q;
    assign sum        = sum_q;
    assign detect     = detect_q;
    assign done       = done_q;
    assign dbg_state  = (state_q == SCAN);

endmodule

// File: tb/tb_arr_peak_search.sv
// Directed and randomized frames for arr_peak_search, checked every cycle against a
// frame-level reference model (max / argmax / second / sum of the collected samples).
module tb_arr_peak_search;

    localparam int IN_W  = 30;
    localparam int N     = 64;
    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = IN_W + $clog2(N);

    logic                     clk = 1'b0;
    logic                     resetn;
    logic signed [IN_W-1:0]   R_in;
    logic                     we;
    logic                     clr;
    logic signed [IN_W-1:0]   threshold;
    logic signed [IN_W-1:0]   peak_val;
    logic [IDX_W-1:0]         peak_idx;
    logic signed [IN_W-1:0]   second_val;
    logic signed [SUM_W-1:0]  sum;
    logic                     detect;
    logic                     done;
    logic                     dbg_state;

    arr_peak_search #(.IN_WIDTH(IN_W), .N_args(N)) dut (
        .clk(clk), .resetn(resetn), .R_in(R_in), .we(we), .clr(clr),
        .threshold(threshold), .peak_val(peak_val), .peak_idx(peak_idx),
        .second_val(second_val), .sum(sum), .detect(detect), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // reference model state
    logic signed [IN_W-1:0]  cur_q[$];
    logic signed [IN_W-1:0]  exp_peak;
    logic [IDX_W-1:0]        exp_idx;
    logic signed [IN_W-1:0]  exp_sec;
    logic signed [SUM_W-1:0] exp_sum;
    logic                    exp_det;
    logic                    exp_done;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    int done_gap = 0;
    int done_count = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        exp_peak = '0; exp_idx = '0; exp_sec = '0; exp_sum = '0;
        exp_det = 1'b0; exp_done = 1'b0;
    endtask

    // Frame result straight from the collected samples.
    task automatic model_finish_frame();
        longint s;
        int     pi;
        logic signed [IN_W-1:0] sec;
        pi = 0;
        for (int i = 1; i < N; i++)
            if (cur_q[i] > cur_q[pi]) pi = i;
        sec = {1'b1, {(IN_W-1){1'b0}}};
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (i != pi && cur_q[i] > sec) sec = cur_q[i];
            s += longint'(cur_q[i]);
        end
        exp_peak = cur_q[pi];
        exp_idx  = IDX_W'(pi);
        exp_sec  = sec;
        exp_sum  = SUM_W'(s);
        exp_det  = (cur_q[pi] > threshold);
        exp_done = 1'b1;
        cur_q.delete();
    endtask

    task automatic model_edge();
        exp_done = 1'b0;
        if (clr) cur_q.delete();
        else if (we) begin
            cur_q.push_back(R_in);
            if (cur_q.size() == N) model_finish_frame();
        end
    endtask

    task automatic check_all();
        chk("done", done, exp_done);
        chk("peak_val", peak_val, exp_peak);
        chk("peak_idx", peak_idx, exp_idx);
        chk("second_val", second_val, exp_sec);
        chk("sum", sum, exp_sum);
        chk("detect", detect, exp_det);
        if (done === 1'b1) begin
            done_count++;
            if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
    endtask

    task automatic step(input logic w, input logic signed [IN_W-1:0] r, input logic c);
        @(negedge clk);
        we = w; R_in = r; clr = c;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] rnd;
        int          dc;

        resetn = 1'b0; we = 1'b0; clr = 1'b0; R_in = '0; threshold = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // ramp 0..63
        threshold = 10;
        for (int k = 0; k < N; k++) step(1'b1, IN_W'(k), 1'b0);
        chk("ramp_done", done, 1'b1);
        chk("ramp_peak", peak_val, 63);
        chk("ramp_idx", peak_idx, 63);
        chk("ramp_sec", second_val, 62);
        chk("ramp_sum", sum, 2016);
        chk("ramp_det", detect, 1'b1);
        idle(2);

        // constant 5, tie keeps earliest index
        threshold = 5;
        for (int k = 0; k < N; k++) step(1'b1, 5, 1'b0);
        chk("const_peak", peak_val, 5);
        chk("const_idx", peak_idx, 0);
        chk("const_sec", second_val, 5);
        chk("const_sum", sum, 320);
        chk("const_det", detect, 1'b0);

        // spike at 17 with we toggling
        dc = done_count;
        for (int k = 0; k < N; k++) begin
            step(1'b1, (k == 17) ? IN_W'(1000) : IN_W'(3), 1'b0);
            if (k < N - 1) step(1'b0, 77, 1'b0);
        end
        chk("spike_one_done", done_count - dc, 1);
        chk("spike_idx", peak_idx, 17);
        chk("spike_sec", second_val, 3);
        chk("spike_sum", sum, 1189);
        idle(1);

        // back-to-back ramp then -7
        threshold = 0;
        for (int k = 0; k < N; k++) step(1'b1, IN_W'(k), 1'b0);
        for (int k = 0; k < N; k++) step(1'b1, -7, 1'b0);
        chk("b2b_gap", done_gap, 64);
        chk("b2b_peak", peak_val, -7);
        chk("b2b_idx", peak_idx, 0);
        chk("b2b_sum", sum, -448);
        chk("b2b_det", detect, 1'b0);
        idle(1);

        // clr after 30 samples (with a same-cycle sample that must be dropped)
        dc = done_count;
        for (int k = 0; k < 30; k++) step(1'b1, IN_W'(500 + k), 1'b0);
        step(1'b1, 9999, 1'b1);
        for (int k = 0; k < N; k++) step(1'b1, (k == 40) ? IN_W'(9) : IN_W'(2), 1'b0);
        chk("clr_one_done", done_count - dc, 1);
        chk("clr_idx", peak_idx, 40);
        chk("clr_sum", sum, 135);

        // clr coinciding with frame end
        dc = done_count;
        for (int k = 0; k < N - 1; k++) step(1'b1, IN_W'(k), 1'b0);
        step(1'b1, 12345, 1'b1);
        idle(1);
        chk("clr_end_no_done", done_count - dc, 0);

        // reset mid-frame
        for (int k = 0; k < 20; k++) step(1'b1, IN_W'(k * 11), 1'b0);
        @(negedge clk);
        resetn = 1'b0; we = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        for (int k = 0; k < N; k++) step(1'b1, IN_W'(3 * k - 50), 1'b0);
        chk("post_rst_idx", peak_idx, 63);

        // randomized frames with gaps, occasional clr and tie-prone values
        for (int f = 0; f < 6; f++) begin
            rnd = $urandom;
            threshold = rnd[IN_W-1:0];
            for (int k = 0; k < 90; k++) begin
                rnd = $urandom;
                if (f % 2 == 0) R_in = rnd[IN_W-1:0];
                else R_in = IN_W'($signed($urandom_range(0, 7)) - 4);
                step($urandom_range(0, 3) != 0, R_in, $urandom_range(0, 60) == 0);
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
